// File: rtl/timer_pkg.sv
// Shared constants for the stopwatch/timer core: FSM encoding and width defaults.
package timer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned PRE_DIV_DEF   = 4;
  localparam int unsigned LAP_DEPTH_DEF = 4;

  // Pointer/counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/timer_ctrl_core_if.sv
// Command/status bundle between the button logic (master) and the timer core (slave).
interface timer_ctrl_core_if #(
  parameter int unsigned CNT_W = timer_pkg::CNT_W_DEF
) ();
  logic             start;
  logic             stop;
  logic             reset;
  logic             lap;
  logic             mode_down;
  logic [CNT_W-1:0] load_val;
  logic             lap_rd;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             wrap;
  logic             cleared;
  logic [CNT_W-1:0] lap_data;
  logic             lap_valid;
  logic             lap_full;
  logic             lap_ovf;

  modport master (
    output start, stop, reset, lap, mode_down, load_val, lap_rd,
    input  state, count, done, wrap, cleared, lap_data, lap_valid, lap_full, lap_ovf
  );

  modport slave (
    input  start, stop, reset, lap, mode_down, load_val, lap_rd,
    output state, count, done, wrap, cleared, lap_data, lap_valid, lap_full, lap_ovf
  );
endinterface

// File: rtl/timer_ctrl_core_lap_fifo.sv
// First-word-fall-through FIFO for lap times; the head is held in its own register.
module lap_fifo
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W_DEF,
  parameter int unsigned DEPTH = LAP_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == LVL_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // A push that lands in an empty (or just-drained) FIFO becomes the new head directly.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;
    head_d = head_q;
    if (flush) begin
      wr_d   = '0;
      rd_d   = '0;
      lvl_d  = '0;
      head_d = '0;
    end else begin
      wr_d  = wr_q + PTR_W'(push_ok);
      rd_d  = rd_q + PTR_W'(pop_ok);
      lvl_d = lvl_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
      if (lvl_d == '0) begin
        head_d = '0;
      end else if (push_ok && (lvl_q == LVL_W'(pop_ok))) begin
        head_d = data_in;
      end else begin
        head_d = mem_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      head_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      head_q <= head_d;
      if (push_ok && !flush) mem_q[wr_q] <= data_in;
    end
  end

  assign data_out = head_q;

endmodule

// File: rtl/timer_ctrl_core.sv
// Stopwatch/timer: run/pause FSM, prescaled up/down counter and lap-capture buffer.
module timer_ctrl_core
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned PRE_DIV   = PRE_DIV_DEF,
  parameter int unsigned LAP_DEPTH = LAP_DEPTH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  timer_ctrl_core_if.slave  bus
);
  localparam int unsigned PRE_W = clog2_min1(PRE_DIV);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             cleared_q, cleared_d;

  logic             go, tick;
  logic             lap_req, lap_pop, lap_drop;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_head;

  // stop outranks start, so a simultaneous start is discarded.
  assign go   = bus.start && !bus.stop;
  assign tick = (state_q == ST_RUNNING) && (pre_q == PRE_W'(PRE_DIV - 1));

  assign lap_req  = bus.lap && !bus.reset &&
                    ((state_q == ST_RUNNING) || (state_q == ST_PAUSED));
  assign lap_pop  = bus.lap_rd && !bus.reset && !fifo_empty;
  assign lap_drop = lap_req && fifo_full && !lap_pop;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    dir_d     = dir_q;
    wrap_d    = wrap_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    cleared_d = 1'b0;
    if (bus.reset) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      pre_d     = '0;
      wrap_d    = 1'b0;
      ovf_d     = 1'b0;
      cleared_d = 1'b1;
    end else begin
      if (lap_drop) ovf_d = 1'b1;
      case (state_q)
        ST_IDLE, ST_EXPIRED: begin
          cnt_d = '0;
          if (go) begin
            dir_d = bus.mode_down;
            pre_d = '0;
            state_d = ST_RUNNING;
            if (bus.mode_down) begin
              cnt_d = bus.load_val;
              if (bus.load_val == '0) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
              end
            end
          end
        end
        ST_RUNNING: begin
          if (bus.stop) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            pre_d = '0;
            if (!dir_q) begin
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_q == '1) wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
              if (cnt_q == CNT_W'(1)) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
              end
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        ST_PAUSED: begin
          if (go) state_d = ST_RUNNING;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      dir_q     <= 1'b0;
      wrap_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      cleared_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      cleared_q <= cleared_d;
    end
  end

  lap_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (lap_req),
    .pop      (lap_pop),
    .flush    (bus.reset),
    .data_in  (cnt_q),
    .data_out (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign bus.state     = state_q;
  assign bus.count     = cnt_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;
  assign bus.cleared   = cleared_q;
  assign bus.lap_data  = fifo_head;
  assign bus.lap_valid = !fifo_empty;
  assign bus.lap_full  = fifo_full;
  assign bus.lap_ovf   = ovf_q;

endmodule

// File: tb/tb_timer_ctrl_core.sv
// Bench for timer_ctrl_core: two configurations share one command stream, each scored against its own model.
module tb_timer_ctrl_core;
  localparam int W0 = 8;
  localparam int P0 = 4;
  localparam int W1 = 4;
  localparam int P1 = 1;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_ctrl_core_if #(.CNT_W(W0)) if0 ();
  timer_ctrl_core_if #(.CNT_W(W1)) if1 ();

  timer_ctrl_core #(.CNT_W(W0), .PRE_DIV(P0), .LAP_DEPTH(D)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  timer_ctrl_core #(.CNT_W(W1), .PRE_DIV(P1), .LAP_DEPTH(D)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct {
    int k; int st; int cnt; int done; int wrap; int clr; int ld; int lv; int lf; int lo;
  } obs_t;

  obs_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: plain integers plus an array-backed lap list per instance.
  int m_st[2], m_cnt[2], m_pre[2], m_dir[2], m_wrap[2], m_ovf[2], m_done[2], m_clr[2], m_n[2];
  int m_buf[2][D];

  function automatic int wid(int k);  return (k == 0) ? W0 : W1; endfunction
  function automatic int pdiv(int k); return (k == 0) ? P0 : P1; endfunction

  function automatic void model_rst(int k);
    m_st[k] = 0; m_cnt[k] = 0; m_pre[k] = 0; m_dir[k] = 0; m_wrap[k] = 0;
    m_ovf[k] = 0; m_done[k] = 0; m_clr[k] = 0; m_n[k] = 0;
  endfunction

  function automatic void model_step(int k, bit st, bit sp, bit rs, bit lp, bit md, int lv, bit rd);
    int mask = (1 << wid(k)) - 1;
    int lvk = lv & mask;
    bit go = st && !sp;
    m_done[k] = 0;
    m_clr[k] = 0;
    if (rs) begin
      m_st[k] = 0; m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0;
      m_n[k] = 0; m_clr[k] = 1;
      return;
    end
    if (rd && m_n[k] > 0) begin
      for (int i = 0; i < D - 1; i++) m_buf[k][i] = m_buf[k][i+1];
      m_n[k]--;
    end
    if (lp && (m_st[k] == 1 || m_st[k] == 2)) begin
      if (m_n[k] < D) begin
        m_buf[k][m_n[k]] = m_cnt[k];
        m_n[k]++;
      end else begin
        m_ovf[k] = 1;
      end
    end
    case (m_st[k])
      0, 3: begin
        m_cnt[k] = 0;
        if (go) begin
          m_dir[k] = md;
          m_pre[k] = 0;
          m_st[k] = 1;
          if (md) begin
            m_cnt[k] = lvk;
            if (lvk == 0) begin m_st[k] = 3; m_done[k] = 1; end
          end
        end
      end
      1: begin
        if (sp) begin
          m_st[k] = 2;
        end else begin
          m_pre[k]++;
          if (m_pre[k] == pdiv(k)) begin
            m_pre[k] = 0;
            if (m_dir[k] == 0) begin
              if (m_cnt[k] == mask) begin m_cnt[k] = 0; m_wrap[k] = 1; end
              else m_cnt[k]++;
            end else begin
              m_cnt[k]--;
              if (m_cnt[k] == 0) begin m_st[k] = 3; m_done[k] = 1; end
            end
          end
        end
      end
      default: if (go) m_st[k] = 1;
    endcase
  endfunction

  function automatic obs_t model_obs(int k);
    obs_t o;
    o.k = k; o.st = m_st[k]; o.cnt = m_cnt[k]; o.done = m_done[k]; o.wrap = m_wrap[k];
    o.clr = m_clr[k]; o.ld = (m_n[k] > 0) ? m_buf[k][0] : 0; o.lv = (m_n[k] > 0) ? 1 : 0;
    o.lf = (m_n[k] == D) ? 1 : 0; o.lo = m_ovf[k];
    return o;
  endfunction

  function automatic obs_t dut_obs(int k);
    obs_t o;
    o.k = k;
    if (k == 0) begin
      o.st = int'(if0.state); o.cnt = int'(if0.count); o.done = int'(if0.done); o.wrap = int'(if0.wrap);
      o.clr = int'(if0.cleared); o.ld = int'(if0.lap_data); o.lv = int'(if0.lap_valid);
      o.lf = int'(if0.lap_full); o.lo = int'(if0.lap_ovf);
    end else begin
      o.st = int'(if1.state); o.cnt = int'(if1.count); o.done = int'(if1.done); o.wrap = int'(if1.wrap);
      o.clr = int'(if1.cleared); o.ld = int'(if1.lap_data); o.lv = int'(if1.lap_valid);
      o.lf = int'(if1.lap_full); o.lo = int'(if1.lap_ovf);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  task automatic cmp(input obs_t a, input obs_t e);
    chk("state", e.k, a.st, e.st);
    chk("count", e.k, a.cnt, e.cnt);
    chk("done", e.k, a.done, e.done);
    chk("wrap", e.k, a.wrap, e.wrap);
    chk("cleared", e.k, a.clr, e.clr);
    chk("lap_data", e.k, a.ld, e.ld);
    chk("lap_valid", e.k, a.lv, e.lv);
    chk("lap_full", e.k, a.lf, e.lf);
    chk("lap_ovf", e.k, a.lo, e.lo);
  endtask

  // Monitor: every expectation queued for the last edge is compared mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      obs_t e;
      e = sb.pop_front();
      cmp(dut_obs(e.k), e);
    end
  end

  task automatic drive(input bit st, input bit sp, input bit rs, input bit lp, input bit md,
                       input int lv, input bit rd);
    if0.start = st; if0.stop = sp; if0.reset = rs; if0.lap = lp; if0.mode_down = md;
    if0.load_val = W0'(lv); if0.lap_rd = rd;
    if1.start = st; if1.stop = sp; if1.reset = rs; if1.lap = lp; if1.mode_down = md;
    if1.load_val = W1'(lv); if1.lap_rd = rd;
  endtask

  task automatic cyc(input bit st, input bit sp, input bit rs, input bit lp, input bit md,
                     input int lv, input bit rd);
    drive(st, sp, rs, lp, md, lv, rd);
    for (int k = 0; k < 2; k++) model_step(k, st, sp, rs, lp, md, lv, rd);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) sb.push_back(model_obs(k));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string nm);
    obs_t z;
    for (int k = 0; k < 2; k++) begin
      z = '{default: 0};
      z.k = k;
      cmp(dut_obs(k), z);
    end
    chk(nm, 0, int'(if0.count), 0);
  endtask

  // Asserted mid-cycle; outputs must already be zero before the next edge.
  task automatic async_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero("async_rst");
    for (int k = 0; k < 2; k++) model_rst(k);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  bit r_rs, r_sp, r_st, r_lp, r_rd, r_md;
  int r_lv;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) model_rst(k);
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    rst_n = 1'b1;

    // Up count held running for 40 cycles.
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (40) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("t1_count", 0, int'(if0.count), 10);
    chk("t1_state", 0, int'(if0.state), 1);
    chk("t1_done", 0, int'(if0.done), 0);
    chk("t1_count", 1, int'(if1.count), 8);

    // Wrap after exactly 16 ticks, then reset command.
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(16);
    chk("t5_count", 1, int'(if1.count), 0);
    chk("t5_wrap", 1, int'(if1.wrap), 1);
    cyc(0, 0, 1, 1, 0, 0, 1);
    chk("t5_cleared", 1, int'(if1.cleared), 1);
    chk("t5_wrap_clr", 1, int'(if1.wrap), 0);
    idle(1);
    chk("t5_cleared_pulse", 1, int'(if1.cleared), 0);

    // Countdown from 3 to EXPIRED, then from 0 straight to EXPIRED.
    cyc(1, 0, 0, 0, 1, 3, 0);
    chk("t2_load", 1, int'(if1.count), 3);
    idle(3);
    chk("t2_state", 1, int'(if1.state), 3);
    chk("t2_done", 1, int'(if1.done), 1);
    idle(3);
    chk("t2_done_pulse", 1, int'(if1.done), 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("t2_zero_load", 1, int'(if1.done), 1);
    cyc(0, 0, 1, 0, 0, 0, 0);

    // Pause suppresses the coincident tick and resumes cleanly.
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(5);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("t3_pause_cnt", 1, int'(if1.count), 5);
    chk("t3_pause_st", 1, int'(if1.state), 2);
    idle(10);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("t3_resume", 1, int'(if1.count), 6);
    cyc(0, 0, 1, 0, 0, 0, 0);

    // Laps at counts 2,4,6,8,10 into a depth-4 buffer, then drain.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 11; i++) cyc(0, 0, 0, (i % 2 == 1) && (i >= 3), 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("t4_full", 1, int'(if1.lap_full), 1);
    chk("t4_ovf", 1, int'(if1.lap_ovf), 1);
    chk("t4_head", 1, int'(if1.lap_data), 2);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t4_empty", 1, int'(if1.lap_valid), 0);
    cyc(0, 0, 1, 0, 0, 0, 0);

    // rst_n mid-run with laps buffered, then a normal restart.
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    async_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(8);
    chk("t6_count", 1, int'(if1.count), 8);

    // Randomised command mix.
    for (int i = 0; i < 3000; i++) begin
      r_rs = ($urandom_range(0, 99) < 2);
      r_sp = ($urandom_range(0, 99) < 10);
      r_st = ($urandom_range(0, 99) < 25);
      r_lp = ($urandom_range(0, 99) < 25);
      r_rd = ($urandom_range(0, 99) < 20);
      r_md = 1'($urandom_range(0, 1));
      r_lv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 255));
      cyc(r_st, r_sp, r_rs, r_lp, r_md, r_lv, r_rd);
      if (i % 1000 == 500) async_reset();
    end

    idle(1);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl_core.md
Name: timer_ctrl_core

Overview:
Parametrised stopwatch/timer core that merges the run/pause control FSM with the count datapath. Adds these capabilities:
- Programmable prescaler.
- Configurable counter width.
- Up-count or countdown mode with an EXPIRED state.
- A lap-capture buffer for split times.

It sits between the debounced button/command logic and the display/readout path.

Parameters:
CNT_W, 16, counter width in bits (>=2)
PRE_DIV, 4, clock cycles per count tick while RUNNING (>=1; 1 = tick every cycle)
LAP_DEPTH, 4, lap buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  start/resume command, level sampled each cycle
stop  in  1  pause command
reset  in  1  synchronous clear command (distinct from rst_n)
lap  in  1  capture current count into lap buffer
mode_down  in  1  0 = count up, 1 = count down; sampled only on start from IDLE or EXPIRED
load_val  in  CNT_W  countdown start value; sampled with mode_down
lap_rd  in  1  pop lap buffer head
state  out  2  FSM state (IDLE/RUNNING/PAUSED/EXPIRED)
count  out  CNT_W  current count
done  out  1  one-cycle pulse on entry to EXPIRED
wrap  out  1  sticky: up-count wrapped from all-ones to 0
cleared  out  1  one-cycle pulse, cycle after reset command accepted
lap_data  out  CNT_W  lap buffer head (first-word-fall-through)
lap_valid  out  1  lap buffer not empty
lap_full  out  1  lap buffer full
lap_ovf  out  1  sticky: lap dropped because buffer full

Behaviour:
- rst_n low, asynchronous: every register and output goes to 0.
  - state=IDLE, count=0, done=0, wrap=0, cleared=0.
  - Lap buffer empty: lap_valid=0, lap_full=0, lap_ovf=0, lap_data=0.
  - Prescaler=0, latched direction dir_q=0.
- Command priority each cycle: reset > stop > start.
- reset command, any state: next state IDLE; count, prescaler, wrap, lap_ovf cleared; lap buffer flushed; cleared=1 next cycle.
  - Simultaneous lap or lap_rd is ignored.
- IDLE: count held 0.
  - On start: dir_q<=mode_down and prescaler<=0.
  - Up mode: count stays 0.
  - Down mode: count<=load_val.
  - Next state RUNNING, except down mode with load_val==0: next state EXPIRED and done pulses.
- RUNNING: prescaler counts 0..PRE_DIV-1 and tick fires in the cycle where prescaler==PRE_DIV-1.
  - Up tick: count+1, modulo 2^CNT_W. The all-ones->0 transition sets wrap.
  - Down tick: count-1. A tick at count==1 makes count 0, next state EXPIRED, done=1 for one cycle.
  - stop: next state PAUSED. That cycle's tick and prescaler advance are suppressed. Prescaler value is retained.
  - start while RUNNING is ignored.
- PAUSED: count and prescaler hold.
  - start: RUNNING; prescaler resumes from the retained value; dir_q unchanged.
  - stop is ignored.
- EXPIRED: count holds 0.
  - start: re-samples mode_down/load_val as from IDLE (restart).
  - reset: IDLE.
- Lap, in RUNNING or PAUSED only:
  - Pushes the registered count visible that cycle (the pre-update value).
  - If full and no same-cycle pop: the entry is dropped and lap_ovf is set.
  - Push and pop in the same cycle when full: both are accepted.
  - lap in IDLE/EXPIRED is ignored.
- lap_rd when empty is ignored. lap_rd is legal in any state.
- Lap buffer contents survive stop/start/EXPIRED; only reset or rst_n clears them.
- Outputs state, count, wrap, lap_* are registered; done and cleared are registered pulses.
- rst_n deassertion mid-count: the block restarts in IDLE; no command is needed to recover.

Decomposition:
- Shared package timer_pkg holds:
  - State encoding localparams: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, EXPIRED=2'd3.
  - Shared width defaults.
- Sub-module lap_fifo: synchronous FWFT FIFO, parameters WIDTH/DEPTH.
  - Ports push/pop/flush/data_in/data_out/empty/full, same clk/rst_n.
  - Owned and instantiated once by timer_ctrl_core.

Test Plan:
1. CNT_W=8, PRE_DIV=4, up mode; start; hold for 40 cycles -> count=10 (first tick on cycle 4 after entry to RUNNING), state=1, done=0.
2. Down mode, load_val=3, PRE_DIV=1; start -> count goes 3,2,1,0; state=3 on the cycle count hits 0; done high exactly one cycle; further cycles hold 0.
3. Up mode, PRE_DIV=1; run 5 cycles; stop and tick together -> count=5, state=2; wait 10 cycles -> count stays 5; start -> count resumes at 6 after one tick.
4. lap at counts 2,4,6,8,10 with LAP_DEPTH=4 -> lap_full=1 after 4th push, lap_ovf=1 after 5th; pops return 2,4,6,8; then lap_valid=0.
5. CNT_W=4, PRE_DIV=1, up mode; run 16 ticks -> count=0, wrap=1; reset -> cleared pulses the next cycle, wrap=0, state=0, lap buffer empty.
6. rst_n asserted mid-RUNNING with 2 laps buffered -> all outputs 0 immediately (asynchronous), state=IDLE, lap_valid=0; release rst_n and start -> normal counting.
